rr_moore_arbiter: RTL
=====================

Name: rr_moore_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource (e.g. a shared Moore FSM datapath) among N requesters.
- Built as a Moore machine: every output is decoded from registered state only, with no combinational path from req to grant.
- A mandatory one-cycle RELEASE turnaround separates consecutive grants, so ownership never switches back-to-back.

Parameters:
- N, 4, number of requesters (2..16).
- ID_W, 2, width of grant_id; must satisfy 2**ID_W >= N.
- MAX_HOLD, 8, max consecutive GRANT cycles per owner when timeout is compiled in (2..255).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  N  request vector; bit i high = requester i wants the resource.
- grant  output  N  one-hot grant (all-zero when no owner); registered.
- grant_id  output  ID_W  index of current owner; 0 when no owner.
- busy  output  1  high while state is GRANT.
- timeout  output  1  one-cycle pulse in the RELEASE cycle that follows a forced release.

Behaviour:
- Clocking/reset: one clock. Reset is asynchronous and active-low, applied on reset_n low.
- Reset values: state=IDLE, ptr=0, owner=0, hold_cnt=0, grant=0, grant_id=0, busy=0, timeout=0. Outputs clear immediately on reset_n low, without waiting for clk.
- States: IDLE, GRANT, RELEASE. Encoding is free. Outputs decode from state/owner/flag registers only.
- Arbitration function (used in IDLE and RELEASE):
  - winner = first i with req[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - req is sampled at the rising edge.
- IDLE:
  - grant=0, busy=0.
  - If |req, next state is GRANT and owner <= winner; otherwise stay in IDLE.
- GRANT:
  - grant = 1<<owner, grant_id = owner, busy=1.
  - Stay while req[owner]=1. Requests from other bits are ignored: no preemption.
  - If req[owner]=0 is sampled, go to RELEASE and set ptr <= (owner+1) mod N.
- RELEASE:
  - Lasts exactly 1 cycle. grant=0, busy=0, grant_id=0.
  - Arbitrates using the updated ptr. If |req, go to GRANT with the new owner; else go to IDLE.
- Latency:
  - Request in IDLE sampled at edge k -> grant visible after edge k, i.e. 1 cycle.
  - Owner drops req at edge k -> grant low after edge k. Next owner's grant is high after edge k+1.
- Fairness: the owner moves to lowest priority after every release. With all N requesting continuously, each owner gets one tenure per N tenures.
- Simultaneous events:
  - The owner drops req in the same cycle another requester raises its req: normal RELEASE, then the new requester wins if it is first from ptr.
  - A requester that deasserts req during RELEASE is not granted.
- Edge cases:
  - req bits at index >= N do not exist.
  - With N not a power of two, the ptr wrap is (N-1) -> 0.
  - grant_id values >= N never occur.
- Reset mid-GRANT: grant drops asynchronously and ptr returns to 0, so fairness history is lost.

Optional Feature:
- Macro: HOLD_TIMEOUT_EN.
- Defined:
  - hold_cnt clears on GRANT entry and increments each GRANT cycle.
  - When hold_cnt == MAX_HOLD-1 and req[owner] is still 1, the next state is forced to RELEASE, ptr <= owner+1, and timeout=1 during that RELEASE cycle.
  - A sole requester is re-granted after the RELEASE cycle, giving the pattern MAX_HOLD on, 1 off.
- Not defined:
  - Tenure is unbounded and no hold_cnt logic is present.
  - The timeout port still exists and is tied to 0.

Test Plan:
- Reset/async: drive reset_n=0 mid-cycle while in GRANT with owner=2 -> grant=0, busy=0, grant_id=0 immediately (before the next clk edge). After release, req=4'b0001 -> grant=4'b0001 one cycle later.
- Single request: in IDLE, req=4'b0100 at edge k -> after edge k grant=4'b0100, grant_id=2, busy=1. Drop req at edge k+3 -> RELEASE (grant=0) then IDLE.
- Round-robin sweep: req=4'b1111 held constant, each owner drops its bit for one cycle after 2 GRANT cycles -> grant order 0001, 1000 is not next; expected sequence 0001,0010,0100,1000,0001 with a 1-cycle gap of grant=0 between tenures.
- No preemption: owner=1 holding. Raise req[0] and req[3] -> grant stays 4'b0010 until req[1] drops. Next winner is 3 (ptr=2, bit 2 low), then 0.
- Non-power-of-two: N=3, ID_W=2, req=3'b111 -> grant_id cycles 0,1,2,0 and never reads 3.
- Timeout (HOLD_TIMEOUT_EN, MAX_HOLD=8): req=4'b0011 held -> owner 0 granted exactly 8 cycles, then RELEASE with timeout=1, then owner 1 for 8 cycles. With req=4'b0001 only -> 8 on / 1 off, repeating. Without the macro -> grant=4'b0001 held indefinitely, timeout stays 0.

Source files
------------

// File: rtl/rr_moore_arbiter.sv
// Round-robin Moore arbiter: IDLE -> GRANT -> RELEASE, outputs decoded from registers only.
// Optional hold timeout compiled in with `define HOLD_TIMEOUT_EN.
module rr_moore_arbiter #(
    parameter int N        = 4,
    parameter int ID_W     = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            busy,
    output logic            timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_RELEASE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] w_ptr_nxt;
    logic [ID_W-1:0] r_owner;
    logic [ID_W-1:0] w_owner_nxt;
    logic [ID_W-1:0] w_owner_inc;
    logic [ID_W-1:0] w_winner;
    logic            w_found;
    int unsigned     w_idx;

    if (N < 2 || N > 16 || (1 << ID_W) < N || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
        $error("rr_moore_arbiter: illegal parameter set");
    end

    // Circular search starting at r_ptr; first requester found wins.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int unsigned i = 0; i < N; i++) begin
            w_idx = (32'(r_ptr) + i) % N;
            if (!w_found && req[w_idx]) begin
                w_winner = ID_W'(w_idx);
                w_found  = 1'b1;
            end
        end
    end

    assign w_owner_inc = (int'(r_owner) == N - 1) ? '0 : r_owner + 1'b1;

`ifdef HOLD_TIMEOUT_EN
    logic [7:0] r_hold_cnt;
    logic       r_timeout;
    logic       w_timeout_nxt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
`ifdef HOLD_TIMEOUT_EN
        w_timeout_nxt = 1'b0;
`endif
        case (r_state)
            S_IDLE, S_RELEASE: begin
                if (|req) begin
                    w_state_nxt = S_GRANT;
                    w_owner_nxt = w_winner;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GRANT: begin
                if (!req[r_owner]) begin
                    w_state_nxt = S_RELEASE;
                    w_ptr_nxt   = w_owner_inc;
                end
`ifdef HOLD_TIMEOUT_EN
                else if (r_hold_cnt == 8'(MAX_HOLD - 1)) begin
                    w_state_nxt   = S_RELEASE;
                    w_ptr_nxt     = w_owner_inc;
                    w_timeout_nxt = 1'b1;
                end
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
        end
    end

`ifdef HOLD_TIMEOUT_EN
    // Count is zero on GRANT entry because the previous state is never GRANT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_hold_cnt <= (r_state == S_GRANT) ? r_hold_cnt + 8'd1 : '0;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        grant    = '0;
        grant_id = '0;
        busy     = 1'b0;
        if (r_state == S_GRANT) begin
            grant[r_owner] = 1'b1;
            grant_id       = r_owner;
            busy           = 1'b1;
        end
    end

endmodule
